// File: rtl/vga_pkg.sv
// Shared VGA timing presets, default colour type and counter-window helpers.
// Pure declarations: no state, no latency, no flow control.
package vga_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } timing_t;

    // 800x525 and 1056x628 totals respectively
    localparam timing_t VGA_640X480_60  = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam timing_t SVGA_800X600_60 = '{800, 40, 128, 88, 600, 1, 4, 23};

    localparam int COLOR_W_DEF = 4;

    typedef struct packed {
        logic [COLOR_W_DEF-1:0] r;
        logic [COLOR_W_DEF-1:0] g;
        logic [COLOR_W_DEF-1:0] b;
    } rgb_t;

    function automatic logic in_window(input int unsigned cnt, input int unsigned lo,
                                       input int unsigned len);
        return (cnt >= lo) && (cnt < lo + len);
    endfunction

    function automatic logic cnt_bit(input logic [31:0] v, input int unsigned idx);
        return v[idx[4:0]];
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel request/response bus between the timing generator (master) and a frame source (slave).
// Source answers every request one cycle later; there is no backpressure, only pix_valid.
interface vga_timing_gen_if #(
    parameter int HW = 10,
    parameter int VW = 10,
    parameter int CW = 4
);
    logic            pix_req;
    logic [HW-1:0]   pix_x;
    logic [VW-1:0]   pix_y;
    logic [3*CW-1:0] pix_data;
    logic            pix_valid;

    modport master (output pix_req, pix_x, pix_y, input pix_data, pix_valid);
    modport slave  (input pix_req, pix_x, pix_y, output pix_data, pix_valid);
endinterface

// File: rtl/vga_sync_counter.sv
// Free-running h/v raster counters with visible-area, sync-window and frame-origin decode.
// Counters registered, decode combinational from them; never stalls.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HW       = 10,
    parameter int VW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          active_o,
    output logic          hs_act_o,
    output logic          vs_act_o,
    output logic          frame_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o  = h_cnt_q;
    assign v_cnt_o  = v_cnt_q;
    assign active_o = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
    // vsync window depends on v_cnt only, so its edges land on h_cnt=0
    assign hs_act_o = in_window(32'(h_cnt_q), H_ACTIVE + H_FP, H_SYNC);
    assign vs_act_o = in_window(32'(v_cnt_q), V_ACTIVE + V_FP, V_SYNC);
    assign frame_o  = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing + 2-stage pixel pipeline, 2 clk counter-to-pin; source has no backpressure,
// a missing pix_valid blanks rgb and sets sticky underflow. VGA_TEST_PATTERN_EN: internal x/y pattern.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_640X480_60.h_active,
    parameter int H_FP      = VGA_640X480_60.h_fp,
    parameter int H_SYNC    = VGA_640X480_60.h_sync,
    parameter int H_BP      = VGA_640X480_60.h_bp,
    parameter int V_ACTIVE  = VGA_640X480_60.v_active,
    parameter int V_FP      = VGA_640X480_60.v_fp,
    parameter int V_SYNC    = VGA_640X480_60.v_sync,
    parameter int V_BP      = VGA_640X480_60.v_bp,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int COLOR_W   = COLOR_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    vga_timing_gen_if.master     pix,
    input  logic                 underflow_clr,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [3*COLOR_W-1:0] rgb,
    output logic                 frame_start,
    output logic                 underflow
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active, hs_act, vs_act, frame;

    vga_sync_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HW(HW), .VW(VW)
    ) u_cnt (
        .clk(clk), .reset(reset),
        .h_cnt_o(h_cnt), .v_cnt_o(v_cnt),
        .active_o(active), .hs_act_o(hs_act), .vs_act_o(vs_act), .frame_o(frame)
    );

    // Counters sit at (0,0) during reset; gate so no request escapes before release
    assign pix.pix_req = active & reset;
    assign pix.pix_x   = h_cnt;
    assign pix.pix_y   = v_cnt;

    logic s1_req_q, s1_hs_q, s1_vs_q, s1_fs_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_req_q <= 1'b0;
            s1_hs_q  <= 1'b0;
            s1_vs_q  <= 1'b0;
            s1_fs_q  <= 1'b0;
        end else begin
            s1_req_q <= active;
            s1_hs_q  <= hs_act;
            s1_vs_q  <= vs_act;
            s1_fs_q  <= frame;
        end
    end

    logic                 src_vld;
    logic [3*COLOR_W-1:0] src_dat;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] s1_pat_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_pat_q <= '0;
        end else begin
            s1_pat_q <= {cnt_bit(32'(h_cnt), 5), cnt_bit(32'(v_cnt), 5),
                         cnt_bit(32'(h_cnt), 6) ^ cnt_bit(32'(v_cnt), 6)};
        end
    end

    assign src_vld = 1'b1;
    assign src_dat = {{COLOR_W{s1_pat_q[2]}}, {COLOR_W{s1_pat_q[1]}}, {COLOR_W{s1_pat_q[0]}}};
`else
    assign src_vld = pix.pix_valid;
    assign src_dat = pix.pix_data;
`endif

    logic                 hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic                 fs_q, fs_d, underflow_q, underflow_d;
    logic [3*COLOR_W-1:0] rgb_q, rgb_d;

    always_comb begin
        hsync_d     = s1_hs_q ? HSYNC_POL : ~HSYNC_POL;
        vsync_d     = s1_vs_q ? VSYNC_POL : ~VSYNC_POL;
        de_d        = s1_req_q;
        fs_d        = s1_fs_q;
        rgb_d       = (s1_req_q && src_vld) ? src_dat : '0;
        underflow_d = underflow_q;
        // A fresh underflow outranks a simultaneous clear
        if (s1_req_q && !src_vld) begin
            underflow_d = 1'b1;
        end else if (underflow_clr) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync_q     <= ~HSYNC_POL;
            vsync_q     <= ~VSYNC_POL;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
            rgb_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            fs_q        <= fs_d;
            rgb_q       <= rgb_d;
            underflow_q <= underflow_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign rgb         = rgb_q;
    assign frame_start = fs_q;
    assign underflow   = underflow_q;

endmodule
